// File: rtl/io_feeder.sv
// io_feeder: queues bytes for a processor and hands them over one at a time
// whenever the processor sits in its "waiting for input" control state, and
// watches the processor output register for changes.
//
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   wr_en, wr_data       push a byte into the 4-entry input FIFO
//   statechg             processor control state (INPUT_STATE = wants input)
//   halt                 processor halted; parks the feeder in HALTED
//   out1                 processor output register
//   in1, enter           byte presented to the processor and its valid strobe
//   full, empty, count   FIFO status (count 0..4)
//   overflow             sticky: a write arrived while the FIFO was full
//   out_valid            one-cycle pulse when a changed out1 value is captured
//   out_last, out_count  last captured out1 value, saturating capture count
//   done                 halt has been seen
module io_feeder #(
  parameter int         DEPTH       = 4,   // only 4 is supported
  parameter logic [3:0] INPUT_STATE = 4'b1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic [3:0] statechg,
  input  logic       halt,
  input  logic [7:0] out1,
  output logic [7:0] in1,
  output logic       enter,
  output logic       full,
  output logic       empty,
  output logic [2:0] count,
  output logic       overflow,
  output logic       out_valid,
  output logic [7:0] out_last,
  output logic [7:0] out_count,
  output logic       done
);

  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  typedef enum logic [1:0] {IDLE, PRESENT, WAIT_LEAVE, HALTED} state_e;

  state_e      state_q, state_d;
  logic [7:0]  mem_q [DEPTH];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  count_q, count_d;
  logic        ovf_q;
  logic [7:0]  in1_q, in1_d;
  logic        enter_q, enter_d;
  logic        done_q;
  logic [7:0]  hist_q;
  logic        out_valid_q;
  logic [7:0]  out_last_q;
  logic [7:0]  out_count_q;
  logic        push, pop;
  logic        full_w, empty_w;

  assign full_w  = (count_q == DEPTH_C);
  assign empty_w = (count_q == 3'd0);
  assign push    = wr_en && !full_w;

  // ---------------- FIFO ----------------
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      if (wr_en && full_w) ovf_q <= 1'b1;
      count_q <= count_d;
    end
  end

  // ---------------- Hand-off FSM ----------------
  // enter is registered: it rises on the edge leaving PRESENT and falls on the
  // edge leaving WAIT_LEAVE, which is also the single pop for that hand-off.
  // halt overrides everything, including a coincident WAIT_LEAVE exit.
  always_comb begin
    state_d = state_q;
    in1_d   = in1_q;
    enter_d = 1'b0;
    pop     = 1'b0;
    if (halt) begin
      state_d = HALTED;
    end else begin
      case (state_q)
        IDLE: begin
          if (statechg == INPUT_STATE && !empty_w) state_d = PRESENT;
        end
        PRESENT: begin
          in1_d   = mem_q[rd_ptr_q];
          enter_d = 1'b1;
          state_d = WAIT_LEAVE;
        end
        WAIT_LEAVE: begin
          if (statechg != INPUT_STATE) begin
            pop     = 1'b1;
            state_d = IDLE;
          end else begin
            enter_d = 1'b1;
          end
        end
        HALTED: state_d = HALTED;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      in1_q   <= '0;
      enter_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      in1_q   <= in1_d;
      enter_q <= enter_d;
      if (state_d == HALTED) done_q <= 1'b1;
    end
  end

  // ---------------- Output capture ----------------
  // hist_q is the registered copy of out1; a new sample that differs from it
  // is a capture, reported on the same edge that stores the sample.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hist_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= '0;
      out_count_q <= '0;
    end else begin
      hist_q      <= out1;
      out_valid_q <= (out1 != hist_q);
      if (out1 != hist_q) begin
        out_last_q <= out1;
        if (out_count_q != 8'hFF) out_count_q <= out_count_q + 8'd1;
      end
    end
  end

  assign in1       = in1_q;
  assign enter     = enter_q;
  assign full      = full_w;
  assign empty     = empty_w;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_count = out_count_q;
  assign done      = done_q;

endmodule
